// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one ready/valid FIFO write port between C_NUM_PORTS producers.
// Define FIFO_ARB_BURST_EN to let a producer keep the grant for up to C_MAX_BURST beats.
module fifo_write_arbiter #(
  parameter int unsigned C_DATA_WIDTH = 8,
  parameter int unsigned C_NUM_PORTS  = 4,
  parameter int unsigned C_MAX_BURST  = 4,
  localparam int unsigned SRC_W       = $clog2(C_NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [C_NUM_PORTS-1:0]              s_valid,
  output logic [C_NUM_PORTS-1:0]              s_ready,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [C_DATA_WIDTH-1:0]             m_data,
  output logic [SRC_W-1:0]                    m_src
);

  logic                    r_m_valid;
  logic [C_DATA_WIDTH-1:0] r_m_data;
  logic [SRC_W-1:0]        r_m_src;
  logic [SRC_W-1:0]        r_ptr;
  logic [SRC_W-1:0]        w_ptr_d;
  logic                    w_load_en;
  logic                    w_grant_vld;
  logic                    w_hs;
  logic [SRC_W-1:0]        w_grant;
  logic [SRC_W-1:0]        w_grant_inc;
  logic [C_DATA_WIDTH-1:0] w_words [C_NUM_PORTS];

  for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_unpack
    assign w_words[gi] = s_data[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  assign w_load_en = !r_m_valid || m_ready;

  // First valid producer at or after r_ptr, wrapping modulo C_NUM_PORTS.
  always_comb begin
    int unsigned idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = 0;
    for (int unsigned k = 0; k < C_NUM_PORTS; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= C_NUM_PORTS) idx = idx - C_NUM_PORTS;
      if (!w_grant_vld && s_valid[idx[SRC_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant     = idx[SRC_W-1:0];
      end
    end
  end

  // Reset gates the handshake so no producer sees ready while the block is held in reset.
  assign w_hs = w_grant_vld && w_load_en && resetn;

  always_comb begin
    s_ready = '0;
    if (w_hs) s_ready[w_grant] = 1'b1;
  end

  assign w_grant_inc = (w_grant == SRC_W'(C_NUM_PORTS - 1)) ? '0 : w_grant + SRC_W'(1);

`ifdef FIFO_ARB_BURST_EN
  logic [7:0] r_bcnt;
  logic [7:0] w_bcnt_d;
  logic [7:0] w_bcnt_eff;

  // A grant to anyone other than the pointer holder starts a fresh burst.
  always_comb begin
    w_ptr_d    = r_ptr;
    w_bcnt_d   = r_bcnt;
    w_bcnt_eff = (w_grant == r_ptr) ? r_bcnt : '0;
    if (w_hs) begin
      if (32'(w_bcnt_eff) + 32'd1 < C_MAX_BURST) begin
        w_ptr_d  = w_grant;
        w_bcnt_d = w_bcnt_eff + 8'd1;
      end else begin
        w_ptr_d  = w_grant_inc;
        w_bcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_bcnt <= '0;
    else         r_bcnt <= w_bcnt_d;
  end
`else
  logic w_unused_burst;
  assign w_unused_burst = (C_MAX_BURST != 0);

  always_comb begin
    w_ptr_d = r_ptr;
    if (w_hs) w_ptr_d = w_grant_inc;
  end
`endif

  // Drain and reload share one edge, so a full-rate stream sees no bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_src   <= '0;
      r_ptr     <= '0;
    end else begin
      r_ptr <= w_ptr_d;
      if (w_load_en) begin
        r_m_valid <= w_grant_vld;
        if (w_grant_vld) begin
          r_m_data <= w_words[w_grant];
          r_m_src  <= w_grant;
        end
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_src   = r_m_src;

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the team's ready/valid FIFO (`myfifo`) between `C_NUM_PORTS` independent producers. It sits directly in front of the FIFO write side: each producer presents a ready/valid/data stream, and the block grants one producer per cycle. The granted word goes into a one-entry output register that drives the FIFO's `write_valid`/`write_data` and honours its `write_ready`. The block also reports which producer each output word came from.

## Interface
- `C_DATA_WIDTH`, 8, width of each data word (matches FIFO `C_DATA_WIDTH`)
- `C_NUM_PORTS`, 4, number of producers; legal range 2..16
- `C_MAX_BURST`, 4, max consecutive grants to one producer (used only with `FIFO_ARB_BURST_EN`); legal range 1..255
- `SRC_W` (localparam) = `$clog2(C_NUM_PORTS)`

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `s_valid`  in  C_NUM_PORTS  per-producer valid, bit i = producer i
- `s_ready`  out  C_NUM_PORTS  per-producer ready; at most one bit set per cycle
- `s_data`  in  C_NUM_PORTS*C_DATA_WIDTH  producer i occupies bits [i*W +: W]
- `m_valid`  out  1  to FIFO `write_valid`
- `m_ready`  in  1  from FIFO `write_ready`
- `m_data`  out  C_DATA_WIDTH  to FIFO `write_data`
- `m_src`  out  SRC_W  index of the producer that supplied `m_data`

## Operation
- **Output register:** holds `m_valid`/`m_data`/`m_src`.
  - `load_en = !m_valid || m_ready`.
  - On a clock with `load_en` and a grant, the register loads the granted word and sets `m_valid=1`.
  - On a clock with `load_en` and no grant, the register clears `m_valid`.
  - Without `load_en`, the register holds; `m_data`/`m_src` must not change while `m_valid && !m_ready`.
- **Arbitration:** combinational each cycle.
  - Search `s_valid` starting at priority pointer `ptr`, ascending, wrapping modulo `C_NUM_PORTS`.
  - The first set bit is the granted producer `g`.
  - `s_ready[g] = load_en`; all other `s_ready` bits are 0.
  - `s_ready` may depend on `s_valid`. A producer must not make its valid depend on its ready.
- **Pointer update:** on an accepted handshake from `g`, `ptr <= (g+1) mod C_NUM_PORTS` (wraps N-1 -> 0). With no handshake, `ptr` holds.
- **No-loss rule:** every `s_valid[i] && s_ready[i]` beat appears exactly once at the output, in acceptance order. Per-producer order is preserved.
- **Fairness:** with every producer continuously valid and `m_ready=1`, grants rotate 0,1,…,N-1,0,…. No producer waits more than N-1 accepted beats.
- **Reset:** while `resetn=0`: `m_valid=0`, `m_data=0`, `m_src=0`, `ptr=0`, burst counter 0, `s_ready=0`. Asserting reset mid-transfer discards the held word; producers must re-present it.

## Timing
- Latency: a word accepted at edge k appears with `m_valid=1` after edge k (same cycle it was registered) and leaves at the first later edge with `m_ready=1`.
- Throughput: 1 word/clock while `m_ready=1` and any `s_valid` is set.
- Backpressure: with `m_valid=1, m_ready=0`, all `s_ready=0` and `ptr` is frozen.
- Full FIFO (`m_ready=0`) stalls all producers. On `m_ready` rising, the held word drains and a new grant loads on the same edge.
- Simultaneous drain and load on one edge is required; there is no bubble.

## Configuration
- `FIFO_ARB_BURST_EN` undefined: pure round-robin as above; `C_MAX_BURST` ignored.
- `FIFO_ARB_BURST_EN` defined: adds a burst counter `bcnt`.
  - After a handshake from `g`, `ptr` stays at `g` (and `bcnt++`) while `bcnt+1 < C_MAX_BURST`.
  - Otherwise `ptr <= (g+1) mod N` and `bcnt <= 0`.
  - If the holding producer drops `s_valid`, normal search from `ptr` proceeds. When a different producer is granted, `bcnt` resets to 0.
  - Fairness bound becomes (N-1)*C_MAX_BURST beats.

## Test plan
- Reset then all four producers valid with data 'a','b','c','d', `m_ready=1` -> output 'a'(src0),'b'(src1),'c'(src2),'d'(src3), one per clock; `ptr` back to 0.
- Only producer 2 valid, `m_ready` held 0 for 3 clocks, then 1 -> `m_valid=1` with `m_data`/`m_src=2` stable for all stalled cycles; `s_ready`=0 throughout the stall; word emitted once.
- Producers 1 and 3 valid continuously, `m_ready` toggles 1,0,1,0 -> sources alternate 1,3,1,3; no duplicate or dropped word (compare against scoreboard).
- Assert `resetn=0` while `m_valid=1, m_ready=0` -> `m_valid`, `m_data`, `m_src` go 0 immediately (asynchronously); first grant after release is the lowest valid index.
- With `FIFO_ARB_BURST_EN`, `C_MAX_BURST=3`, producers 0 and 1 always valid -> source sequence 0,0,0,1,1,1,0,…; without the macro -> 0,1,0,1.
- Idle (`s_valid=0`) with `m_ready=1` -> `m_valid` drops one clock after the last word drains; `ptr` unchanged.
